// File: rtl/dataio_port_responder.sv
// Load/store data-port responder: turns a core REQ/BUSY request into one word-aligned memory-bus transaction.
// Optional build macro DATAIO_ALIGN_FAULT_EN adds misalignment faulting at accept time.
module dataio_port_responder #(
  parameter logic [7:0] P_TIMEOUT = 8'd255
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iFLUSH,
  // Core side
  input  logic        iDATAIO_REQ,
  output logic        oDATAIO_BUSY,
  input  logic [1:0]  iDATAIO_ORDER,
  input  logic        iDATAIO_RW,
  input  logic [13:0] iDATAIO_TID,
  input  logic [1:0]  iDATAIO_MMUMOD,
  input  logic [31:0] iDATAIO_PDT,
  input  logic [31:0] iDATAIO_ADDR,
  input  logic [31:0] iDATAIO_DATA,
  output logic        oDATAIO_VALID,
  output logic [31:0] oDATAIO_DATA,
  output logic        oDATAIO_FAULT,
  // Memory side
  output logic        oMEM_REQ,
  input  logic        iMEM_ACK,
  output logic        oMEM_RW,
  output logic [29:0] oMEM_ADDR,
  output logic [3:0]  oMEM_BE,
  output logic [31:0] oMEM_WDATA,
  output logic [13:0] oMEM_TID,
  output logic [1:0]  oMEM_MMUMOD,
  output logic [31:0] oMEM_PDT,
  input  logic        iMEM_RVALID,
  input  logic [31:0] iMEM_RDATA
);

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_MREQ  = 2'd1;
  localparam logic [1:0] STATE_MWAIT = 2'd2;
  localparam logic [1:0] STATE_RESP  = 2'd3;

  logic [1:0]  state;
  logic        dropFlag;
  logic        faultFlag;
  logic [7:0]  timeCount;
  logic [31:0] respData;

  logic [3:0]  reqBe;
  logic [31:0] reqWdata;
  logic        misaligned;
  logic        skipMem;
  logic        accept;
  logic        respDrop;
  logic [7:0]  nextCount;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    reqBe      = 4'b0000;
    reqWdata   = 32'h0;
    misaligned = 1'b0;
    case (iDATAIO_ORDER)
      2'b00: begin
        reqBe    = 4'b0001 << iDATAIO_ADDR[1:0];
        reqWdata = {4{iDATAIO_DATA[7:0]}};
      end
      2'b01: begin
        reqBe    = iDATAIO_ADDR[1] ? 4'b1100 : 4'b0011;
        reqWdata = {2{iDATAIO_DATA[15:0]}};
      end
      2'b10: begin
        reqBe    = 4'b1111;
        reqWdata = iDATAIO_DATA;
      end
      default: begin
        reqBe    = 4'b0000;
        reqWdata = 32'h0;
      end
    endcase
`ifdef DATAIO_ALIGN_FAULT_EN
    if (iDATAIO_ORDER == 2'b01)
      misaligned = iDATAIO_ADDR[0];
    else if (iDATAIO_ORDER == 2'b10)
      misaligned = (iDATAIO_ADDR[1:0] != 2'b00);
`endif
  end

  assign skipMem   = (iDATAIO_ORDER == 2'b11) || misaligned;
  assign accept    = iDATAIO_REQ && (state == STATE_IDLE);
  assign nextCount = timeCount + 8'd1;

  // A flush landing in the response cycle itself must still kill a read response.
  assign respDrop  = dropFlag || (iFLUSH && !oMEM_RW);

  assign oDATAIO_BUSY  = (state != STATE_IDLE);
  assign oMEM_REQ      = (state == STATE_MREQ);
  assign oDATAIO_VALID = (state == STATE_RESP) && !oMEM_RW && !respDrop;
  assign oDATAIO_FAULT = (state == STATE_RESP) && faultFlag && !respDrop;
  assign oDATAIO_DATA  = respData;

  // NOTE: asynchronous active-low reset; all state uses <= so each flop samples pre-edge values.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state       <= STATE_IDLE;
      dropFlag    <= 1'b0;
      faultFlag   <= 1'b0;
      timeCount   <= 8'd0;
      respData    <= 32'h0;
      oMEM_RW     <= 1'b0;
      oMEM_ADDR   <= 30'h0;
      oMEM_BE     <= 4'b0000;
      oMEM_WDATA  <= 32'h0;
      oMEM_TID    <= 14'h0;
      oMEM_MMUMOD <= 2'b00;
      oMEM_PDT    <= 32'h0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (accept) begin
            oMEM_RW     <= iDATAIO_RW;
            oMEM_ADDR   <= iDATAIO_ADDR[31:2];
            oMEM_BE     <= reqBe;
            oMEM_WDATA  <= reqWdata;
            oMEM_TID    <= iDATAIO_TID;
            oMEM_MMUMOD <= iDATAIO_MMUMOD;
            oMEM_PDT    <= iDATAIO_PDT;
            respData    <= 32'h0;
            faultFlag   <= misaligned;
            dropFlag    <= iFLUSH && !iDATAIO_RW;
            // Accesses without a bus leg pass through RESP; for writes it only carries FAULT.
            state       <= skipMem ? STATE_RESP : STATE_MREQ;
          end
        end
        STATE_MREQ: begin
          if (iFLUSH && !oMEM_RW)
            dropFlag <= 1'b1;
          if (iMEM_ACK) begin
            timeCount <= 8'd0;
            state     <= oMEM_RW ? STATE_IDLE : STATE_MWAIT;
          end
        end
        STATE_MWAIT: begin
          if (iFLUSH)
            dropFlag <= 1'b1;
          if (iMEM_RVALID) begin
            respData <= iMEM_RDATA;
            state    <= STATE_RESP;
          end else if (nextCount == P_TIMEOUT) begin
            respData  <= 32'hFFFF_FFFF;
            faultFlag <= 1'b1;
            state     <= STATE_RESP;
          end else begin
            timeCount <= nextCount;
          end
        end
        default: begin
          dropFlag <= 1'b0;
          state    <= STATE_IDLE;
        end
      endcase
    end
  end

endmodule
